spi_mem_burst_controller: RTL

Parametrised SPI master for serial flash and PSRAM on a shared bus with NUM_CS chip selects.
- Executes one byte-granular read (0x03) or write (0x02) burst per request.
- Burst length 1..MAX_BURST bytes; address width and SCLK rate are configurable.
- Sits between the CPU bus arbiter (instruction fetch and data access) and the external SPI pins.
- A `busy_out` / ready handshake replaces fixed 16-bit/8-bit transfer types.

---
 rtl/spi_mem_burst_controller.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_burst_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_mem_burst_controller                                      |
// | Purpose  : SPI mode-0 master for serial flash / PSRAM. Runs one byte-     |
// |            granular read (0x03) or write (0x02) burst per request on a    |
// |            shared bus with NUM_CS active-low chip selects.                |
// | Option   : define SPI_FAST_READ_EN for 0x0B fast reads with 8 dummy      |
// |            SCLK periods between address and data.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_mem_burst_controller #(
  parameter int NUM_CS     = 2,
  parameter int ADDR_BYTES = 3,
  parameter int MAX_BURST  = 4,
  parameter int CLK_DIV    = 1,
  parameter int CS_GAP     = 2,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  output logic                    sclk_out,
  output logic                    mosi_out,
  input  logic                    miso_in,
  output logic [NUM_CS-1:0]       cs_n_out,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic [CSW-1:0]          req_cs_in,
  input  logic                    req_write_in,
  input  logic [8*ADDR_BYTES-1:0] req_addr_in,
  input  logic [LW-1:0]           req_len_in,
  input  logic [7:0]              wdata_in,
  output logic                    wdata_ready_out,
  output logic [7:0]              rdata_out,
  output logic                    rdata_valid_out,
  output logic                    done_out,
  output logic                    busy_out
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAPW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int CNTW = (LW > 2) ? LW : 2;

  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [GAPW-1:0] GAP_LAST  = GAPW'(CS_GAP - 1);
  localparam logic [CNTW-1:0] ADDR_LAST = CNTW'(ADDR_BYTES - 1);
  localparam logic [7:0]      WRITE_CMD = 8'h02;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0]      READ_CMD  = 8'h0B;
`else
  localparam logic [7:0]      READ_CMD  = 8'h03;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
`ifdef SPI_FAST_READ_EN
    DUMMY = 3'd5,
`endif
    GAP   = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      shift_reg;
  logic [6:0]      rx_reg;
  logic [AW-1:0]   addr_reg;
  logic [LW-1:0]   len_reg;
  logic            write_reg;
  logic [DIVW-1:0] div_cnt;
  logic [2:0]      bit_cnt;
  logic [CNTW-1:0] byte_cnt;
  logic [GAPW-1:0] gap_cnt;

  logic            active;
  logic            tick;
  logic            rise;
  logic            fall;
  logic            last_bit;
  logic [DIVW-1:0] div_next;
  logic            sclk_next;
  logic            wdata_phase;
  logic            pull_next;
  logic [CNTW-1:0] len_ext;
  logic [CSW-1:0]  cs_sel;
  logic [LW-1:0]   len_sel;

`ifdef SPI_FAST_READ_EN
  assign active = (state == CMD) || (state == ADDR) || (state == DATA) || (state == DUMMY);
`else
  assign active = (state == CMD) || (state == ADDR) || (state == DATA);
`endif

  // SCLK toggles when the divider wraps; the toggle direction marks rise or fall.
  assign tick      = active && (div_cnt == DIV_LAST);
  assign rise      = tick && !sclk_out;
  assign fall      = tick && sclk_out;
  assign last_bit  = (bit_cnt == 3'd7);
  assign div_next  = tick ? '0 : div_cnt + 1'b1;
  assign sclk_next = tick ? ~sclk_out : sclk_out;
  assign len_ext   = CNTW'(len_reg);
  assign mosi_out  = shift_reg[7];

  // The write byte is pulled in the cycle that ends with a byte's final
  // falling edge, so it can be loaded straight into the shifter at that edge.
  assign wdata_phase = write_reg && (((state == ADDR) && (byte_cnt == ADDR_LAST)) ||
                                     ((state == DATA) && (byte_cnt != len_ext)));
  assign pull_next   = active && wdata_phase && last_bit && sclk_next && (div_next == DIV_LAST);

  // Out-of-range request fields fall back to CS 0 and the longest burst.
  assign cs_sel  = ({1'b0, req_cs_in} >= (CSW+1)'(NUM_CS)) ? '0 : req_cs_in;
  assign len_sel = ({1'b0, req_len_in} >= (LW+1)'(MAX_BURST)) ? LW'(MAX_BURST - 1) : req_len_in;

  // Transaction FSM, SCLK divider, shifters and all registered outputs.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state           <= IDLE;
      cs_n_out        <= '1;
      sclk_out        <= 1'b0;
      shift_reg       <= '0;
      rx_reg          <= '0;
      addr_reg        <= '0;
      len_reg         <= '0;
      write_reg       <= 1'b0;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      byte_cnt        <= '0;
      gap_cnt         <= '0;
      req_ready_out   <= 1'b0;
      busy_out        <= 1'b0;
      wdata_ready_out <= 1'b0;
      rdata_out       <= '0;
      rdata_valid_out <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      wdata_ready_out <= pull_next;
      rdata_valid_out <= 1'b0;
      done_out        <= 1'b0;

      if (active) begin
        div_cnt  <= div_next;
        sclk_out <= sclk_next;
      end

      if (rise) begin
        rx_reg <= {rx_reg[5:0], miso_in};
        if ((state == DATA) && !write_reg && last_bit) begin
          rdata_out       <= {rx_reg, miso_in};
          rdata_valid_out <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          req_ready_out <= 1'b1;
          if (req_valid_in && req_ready_out) begin
            state         <= CMD;
            busy_out      <= 1'b1;
            req_ready_out <= 1'b0;
            cs_n_out      <= ~(NUM_CS'(1) << cs_sel);
            shift_reg     <= req_write_in ? WRITE_CMD : READ_CMD;
            addr_reg      <= req_addr_in;
            len_reg       <= len_sel;
            write_reg     <= req_write_in;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            sclk_out      <= 1'b0;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state         <= IDLE;
            busy_out      <= 1'b0;
            req_ready_out <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (!last_bit) begin
              shift_reg <= {shift_reg[6:0], 1'b0};
            end else begin
              case (state)
                CMD: begin
                  state     <= ADDR;
                  byte_cnt  <= '0;
                  shift_reg <= addr_reg[AW-1 -: 8];
                  addr_reg  <= addr_reg << 8;
                end
                ADDR: begin
                  if (byte_cnt == ADDR_LAST) begin
`ifdef SPI_FAST_READ_EN
                    if (!write_reg) begin
                      state     <= DUMMY;
                      shift_reg <= '0;
                    end else
`endif
                    begin
                      state     <= DATA;
                      byte_cnt  <= '0;
                      shift_reg <= write_reg ? wdata_in : 8'h00;
                    end
                  end else begin
                    byte_cnt  <= byte_cnt + 1'b1;
                    shift_reg <= addr_reg[AW-1 -: 8];
                    addr_reg  <= addr_reg << 8;
                  end
                end
`ifdef SPI_FAST_READ_EN
                DUMMY: begin
                  state     <= DATA;
                  byte_cnt  <= '0;
                  shift_reg <= '0;
                end
`endif
                DATA: begin
                  if (byte_cnt == len_ext) begin
                    state     <= GAP;
                    cs_n_out  <= '1;
                    done_out  <= 1'b1;
                    gap_cnt   <= '0;
                    shift_reg <= '0;
                  end else begin
                    byte_cnt  <= byte_cnt + 1'b1;
                    shift_reg <= write_reg ? wdata_in : 8'h00;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
